// File: rtl/corevx_pkg.sv
// Shared core widths and the writeback request bundle.
// No logic; types and constants only.
// Not applicable.
package corevx_pkg;

  localparam int CORE_REG_ADDR_W = 5;
  localparam int CORE_XLEN       = 32;

  typedef struct packed {
    logic [CORE_REG_ADDR_W-1:0] rd;
    logic [CORE_XLEN-1:0]       wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P0   = 2'd1,
    GNT_P1   = 2'd2
  } wb_gnt_e;

endpackage

// File: rtl/corevx_scoreboard.sv
// Pending-write scoreboard for the 32 architectural registers.
// Lookups combinational; set/clear take effect at the next edge.
// issue_ready drops while the requested rd already has a write in flight.
module corevx_scoreboard
  import corevx_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CORE_REG_ADDR_W-1:0] issue_rd,
  output logic                       issue_ready,
  input  logic                       set_en,
  input  logic [CORE_REG_ADDR_W-1:0] set_rd,
  input  logic                       clr_en,
  input  logic [CORE_REG_ADDR_W-1:0] clr_rd,
  input  logic [CORE_REG_ADDR_W-1:0] rs1_addr,
  input  logic [CORE_REG_ADDR_W-1:0] rs2_addr,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [31:0]                pending
);

  logic [31:0] pending_nxt;

  assign issue_ready = !pending[issue_rd];
  assign rs1_busy    = pending[rs1_addr];
  assign rs2_busy    = pending[rs2_addr];

  // Apply the commit clear before the issue set; x0 is never tracked.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_rd] = 1'b0;
    if (set_en) pending_nxt[set_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

endmodule

// File: rtl/corevx_wb_arbiter.sv
// Merges ALU (port 0) and long-latency (port 1) writebacks onto the register-file write port.
// One cycle from acceptance to rd_write; one writeback per cycle.
// Port 0 has priority; port 1 is force-granted after STARVE_LIMIT consecutive losses.
module corevx_wb_arbiter
  import corevx_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [CORE_REG_ADDR_W-1:0] issue_rd,
  output logic                       issue_ready,
  input  logic [CORE_REG_ADDR_W-1:0] rs1_addr,
  input  logic [CORE_REG_ADDR_W-1:0] rs2_addr,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  input  logic                       wb0_valid,
  input  logic [CORE_REG_ADDR_W-1:0] wb0_rd,
  input  logic [CORE_XLEN-1:0]       wb0_wdata,
  output logic                       wb0_ready,
  input  logic                       wb1_valid,
  input  logic [CORE_REG_ADDR_W-1:0] wb1_rd,
  input  logic [CORE_XLEN-1:0]       wb1_wdata,
  output logic                       wb1_ready,
  output logic [CORE_REG_ADDR_W-1:0] rd_addr,
  output logic [CORE_XLEN-1:0]       rd_wdata,
  output logic                       rd_write,
  output logic                       wb_err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_gnt_e     gnt;
  wb_req_t     req0, req1, win;
  logic        accept;
  logic [3:0]  starve_cnt;
  logic        rd_write_q;
  logic [31:0] pending;

  assign req0 = '{rd: wb0_rd, wdata: wb0_wdata};
  assign req1 = '{rd: wb1_rd, wdata: wb1_wdata};

  // Grant selection: starvation override, then port 0 priority; nothing during reset.
  always_comb begin
    gnt = GNT_NONE;
    win = req0;
    if (!rst) begin
      if (wb1_valid && starve_cnt == LIMIT) gnt = GNT_P1;
      else if (wb0_valid)                   gnt = GNT_P0;
      else if (wb1_valid)                   gnt = GNT_P1;
    end
    if (gnt == GNT_P1) win = req1;
  end

  assign wb0_ready = (gnt == GNT_P0);
  assign wb1_ready = (gnt == GNT_P1);
  assign accept    = (gnt != GNT_NONE);

  // Count consecutive port-1 losses to port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (wb1_valid && gnt == GNT_P0) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Output stage: capture winner; x0 writes are accepted but never strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_write_q <= 1'b0;
      rd_addr    <= '0;
      rd_wdata   <= '0;
    end else if (accept) begin
      rd_write_q <= |win.rd;
      rd_addr    <= win.rd;
      rd_wdata   <= win.wdata;
    end else begin
      rd_write_q <= 1'b0;
    end
  end

  // A write held in the output stage when reset arrives must not reach the register file.
  assign rd_write = rd_write_q && !rst;

  // Sticky flag for a writeback to a register with no write in flight.
  always_ff @(posedge clk) begin
    if (rst) wb_err <= 1'b0;
    else if (accept && (|win.rd) && !pending[win.rd]) wb_err <= 1'b1;
  end

  corevx_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .set_en      (issue_valid && issue_ready),
    .set_rd      (issue_rd),
    .clr_en      (rd_write),
    .clr_rd      (rd_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .pending     (pending)
  );

endmodule

// File: doc/corevx_wb_arbiter.md
# corevx_wb_arbiter

Writeback arbiter and scoreboard in front of the 32×32 core register file (one write port, two async read ports, x0 hardwired to zero). Merges two writeback sources into the single register-file write port:
- port 0: ALU, single-cycle.
- port 1: load / mul-div / CSR, long-latency.

It also tracks in-flight destination registers, so decode can stall on RAW hazards and on a second write to the same register (WAW).

## Interface
- STARVE_LIMIT, 4: consecutive port-1 losses before port 1 is force-granted; range 1..15.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- issue_valid  in  1  decode issues an instruction writing issue_rd.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_ready  out  1  issue accepted this cycle.
- rs1_addr, rs2_addr  in  5 each  decode source registers.
- rs1_busy, rs2_busy  out  1 each  the source register has a pending write.
- wb0_valid, wb1_valid  in  1 each  writeback request.
- wb0_rd, wb1_rd  in  5 each  destination register.
- wb0_wdata, wb1_wdata  in  32 each  write data.
- wb0_ready, wb1_ready  out  1 each  writeback accepted this cycle.
- rd_addr  out  5  to register file.
- rd_wdata  out  32  to register file.
- rd_write  out  1  to register file.
- wb_err  out  1  sticky; a writeback targeted a non-pending register.

## Operation
- **Scoreboard:** `pending[31:0]`; `pending[0]` is constant 0.
  - issue_ready = !pending[issue_rd] (always 1 for x0).
  - An accepted issue with a nonzero rd sets the pending bit at the next edge.
- **Busy outputs:** rsN_busy = pending[rsN_addr]. Combinational; no bypass from the output register.
- **Grant rule:** combinational, evaluated every cycle.
  - If wb1_valid and starve_cnt == STARVE_LIMIT, grant port 1.
  - Else if wb0_valid, grant port 0.
  - Else if wb1_valid, grant port 1.
  - Otherwise, no grant.
  - wbN_ready is high only for the granted port; both readys are 0 during rst.
- **starve_cnt:** 4 bits.
  - Increments, saturating at STARVE_LIMIT, when wb1_valid and port 0 is granted.
  - Clears when port 1 is granted or wb1_valid is low.
- **Output stage:** registered.
  - On acceptance: rd_addr / rd_wdata load the winner's values at the edge.
  - rd_write is set for nonzero rd; rd_write is 0 for x0.
  - With no acceptance, rd_write = 0 next cycle; rd_addr / rd_wdata hold their values.
- **Pending clear:** pending[rd_addr] clears at the edge where rd_write is high, which is the same edge the register file commits the data.
- **Simultaneous clear and set, same register:** the issue is blocked, because pending is still 1 that cycle. A clear and a set of different registers both take effect.
- **wb_err:** set at acceptance when pending[wbN_rd] == 0 and the rd is nonzero. The write still proceeds. Cleared only by rst.
- **Reset:** synchronous; all of the following go to 0:
  - pending, starve_cnt, rd_write, rd_addr, rd_wdata, wb_err.
  - A request presented in the reset cycle is not accepted.
  - An output-stage write in flight is dropped.

## Timing
- **Latency:**
  1. Writeback accepted at edge N.
  2. rd_write high during cycle N..N+1.
  3. Register-file data and pending clear both at edge N+1.
  4. Decode sees busy=0 and the new rdata from cycle N+1.
- **Throughput:** one writeback per cycle.
- **Handshake:** wbN_valid/wbN_rd/wbN_wdata must remain stable while valid && !ready. Ready may depend combinationally on both valids; valid must not depend on ready.
- **Issue-to-writeback:** earliest is same-cycle writeback after the issue edge; port 0 may write back in the cycle after issue.

## Structure
- **corevx_pkg additions:**
  - CORE_REG_ADDR_W = 5 and CORE_XLEN = 32.
  - typedef `wb_req_t` {rd[4:0], wdata[31:0]}.
- **Sub-module corevx_scoreboard:** the pending vector, issue_ready, rs1/rs2 busy lookup, set/clear ports.
- **Arbiter body:** grant logic, starve counter, output register and wb_err live in the arbiter body.

## Test plan
- **Reset:** rst high 2 cycles with wb0/wb1 valid → readys 0, rd_write 0, all busy 0, wb_err 0.
- **Port 0 basic:** issue rd=5; next cycle wb0 rd=5, data=0xDEADBEEF → wb0_ready=1; rd_write=1, rd_addr=5 next cycle; rs1_addr=5 busy goes 1→0 on the commit edge.
- **Starvation, STARVE_LIMIT=4:** wb0 and wb1 valid continuously → port 0 wins 4 cycles, port 1 is granted on the 5th; pattern repeats every 5 cycles.
- **WAW stall and simultaneous events:** issue rd=7, then re-issue rd=7 → issue_ready=0 until the commit edge of the rd=7 writeback; in the commit cycle, issuing rd=8 succeeds.
- **x0 and wb_err:**
  - wb1 rd=0 → accepted, rd_write stays 0, wb_err stays 0.
  - wb0 rd=9 while not pending → write occurs, wb_err=1 and sticky until rst.
- **Reset mid-operation:** accept wb1 rd=3, assert rst on the next cycle → rd_write=0 and pending[3]=0 after the edge; no register-file write occurs.
